// File: rtl/qtable_update_sched.sv
// qtable_update_sched: packet scheduler in front of the Q-table update engine.
// Received packets are buffered in a small FIFO. Packets with an invalid type are
// dropped and counted. The scheduler issues one packet at a time: it loads the operand
// registers, pulses upd_en for one cycle, and then waits for upd_done.
//
// Ports:
//   clk, nrst            clock and synchronous active-high reset
//   pkt_valid/pkt_ready  receiver handshake; pkt_ready = fifo_count < FIFO_DEPTH
//   pkt_*                packet fields (pkt_type 3'b000 is invalid)
//   upd_en               one-cycle start pulse to the update engine
//   upd_*                registered operands, held from one pop to the next
//   upd_done             engine completion; only honoured in the WAIT state
//   busy                 high in any state other than IDLE
//   fifo_count           number of queued packets
//   drop_count           saturating count of invalid-type packets
//   timeout_err          sticky watchdog flag
//
// Build option: define QUPD_TIMEOUT_EN to compile in the WAIT watchdog (TIMEOUT_CYC).
module qtable_update_sched #(
  parameter int unsigned WORD_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          pkt_valid,
  output logic                          pkt_ready,
  input  logic [WORD_WIDTH-1:0]         pkt_source_id,
  input  logic [WORD_WIDTH-1:0]         pkt_source_hops,
  input  logic [WORD_WIDTH-1:0]         pkt_cluster_id,
  input  logic [WORD_WIDTH-1:0]         pkt_energy,
  input  logic [WORD_WIDTH-1:0]         pkt_qvalue,
  input  logic [WORD_WIDTH-1:0]         pkt_known_ch,
  input  logic [2:0]                    pkt_type,
  output logic                          upd_en,
  output logic [WORD_WIDTH-1:0]         upd_source_id,
  output logic [WORD_WIDTH-1:0]         upd_source_hops,
  output logic [WORD_WIDTH-1:0]         upd_cluster_id,
  output logic [WORD_WIDTH-1:0]         upd_energy,
  output logic [WORD_WIDTH-1:0]         upd_qvalue,
  output logic [WORD_WIDTH-1:0]         upd_known_ch,
  output logic [2:0]                    upd_type,
  input  logic                          upd_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    drop_count,
  output logic                          timeout_err
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned EntryW = 6 * WORD_WIDTH + 3;

  // Elaboration-time parameter sanity check
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYC == 0) begin : gBadParam
    $error("qtable_update_sched: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYC > 0");
  end

  typedef enum logic [1:0] {sIdle, sFire, sWait} stateType;

  stateType          state;
  logic [EntryW-1:0] fifoMem [FIFO_DEPTH];
  logic [PtrW-1:0]   wrPtr;
  logic [PtrW-1:0]   rdPtr;
  logic [EntryW-1:0] wrEntry;
  logic [EntryW-1:0] rdEntry;
  logic              doPush;
  logic              doWrite;
  logic              doPop;

  assign pkt_ready = fifo_count < CntW'(FIFO_DEPTH);
  assign doPush    = pkt_valid & pkt_ready;
  // Invalid packets are accepted (handshake completes) but never stored
  assign doWrite   = doPush & (pkt_type != 3'b000);
  assign doPop     = (state == sIdle) & (fifo_count != '0);
  assign wrEntry   = {pkt_type, pkt_source_id, pkt_source_hops, pkt_cluster_id,
                      pkt_energy, pkt_qvalue, pkt_known_ch};
  assign rdEntry   = fifoMem[rdPtr];

  // FIFO storage; emptiness is tracked by the pointers, so no reset is needed
  always_ff @(posedge clk) begin
    if (doWrite) fifoMem[wrPtr] <= wrEntry;
  end

  // FIFO pointers, occupancy and drop counter
  always_ff @(posedge clk) begin
    if (nrst) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      fifo_count <= '0;
      drop_count <= '0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + PtrW'(1);
      if (doPop)   rdPtr <= rdPtr + PtrW'(1);
      case ({doWrite, doPop})
        2'b10:   fifo_count <= fifo_count + CntW'(1);
        2'b01:   fifo_count <= fifo_count - CntW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (doPush && pkt_type == 3'b000 && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
    end
  end

`ifdef QUPD_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  logic [TmoW-1:0] waitCnt;
`else
  assign timeout_err = 1'b0;
`endif

  // Issue FSM with registered outputs
  always_ff @(posedge clk) begin
    if (nrst) begin
      state  <= sIdle;
      upd_en <= 1'b0;
      busy   <= 1'b0;
      {upd_type, upd_source_id, upd_source_hops, upd_cluster_id,
       upd_energy, upd_qvalue, upd_known_ch} <= '0;
`ifdef QUPD_TIMEOUT_EN
      waitCnt     <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      case (state)
        sIdle: begin
          if (doPop) begin
            {upd_type, upd_source_id, upd_source_hops, upd_cluster_id,
             upd_energy, upd_qvalue, upd_known_ch} <= rdEntry;
            upd_en <= 1'b1;
            busy   <= 1'b1;
            state  <= sFire;
          end
        end
        sFire: begin
          // Any done seen here belongs to an earlier transaction and is ignored
          upd_en <= 1'b0;
          state  <= sWait;
`ifdef QUPD_TIMEOUT_EN
          waitCnt <= '0;
`endif
        end
        sWait: begin
          if (upd_done) begin
            busy  <= 1'b0;
            state <= sIdle;
`ifdef QUPD_TIMEOUT_EN
            waitCnt <= '0;
          end else if (waitCnt == TmoW'(TIMEOUT_CYC - 1)) begin
            // Last permitted WAIT cycle expired: abandon the packet
            busy        <= 1'b0;
            state       <= sIdle;
            timeout_err <= 1'b1;
            waitCnt     <= '0;
          end else begin
            waitCnt <= waitCnt + TmoW'(1);
`endif
          end
        end
        default: begin
          upd_en <= 1'b0;
          busy   <= 1'b0;
          state  <= sIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qtable_update_sched.sv
// Self-checking bench for qtable_update_sched: directed vector table, hand-written
// multi-cycle sequences and a random run, all compared against a queue-based model.
module tb_qtable_update_sched;

  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int TMO   = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         nrst, pkt_valid, pkt_ready, upd_en, upd_done, busy, timeout_err;
  logic [W-1:0] pkt_source_id, pkt_source_hops, pkt_cluster_id, pkt_energy, pkt_qvalue, pkt_known_ch;
  logic [W-1:0] upd_source_id, upd_source_hops, upd_cluster_id, upd_energy, upd_qvalue, upd_known_ch;
  logic [2:0]   pkt_type, upd_type;
  logic [2:0]   fifo_count;
  logic [7:0]   drop_count;

  qtable_update_sched #(.WORD_WIDTH(W), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .nrst(nrst), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_source_id(pkt_source_id), .pkt_source_hops(pkt_source_hops),
    .pkt_cluster_id(pkt_cluster_id), .pkt_energy(pkt_energy), .pkt_qvalue(pkt_qvalue),
    .pkt_known_ch(pkt_known_ch), .pkt_type(pkt_type), .upd_en(upd_en),
    .upd_source_id(upd_source_id), .upd_source_hops(upd_source_hops),
    .upd_cluster_id(upd_cluster_id), .upd_energy(upd_energy), .upd_qvalue(upd_qvalue),
    .upd_known_ch(upd_known_ch), .upd_type(upd_type), .upd_done(upd_done), .busy(busy),
    .fifo_count(fifo_count), .drop_count(drop_count), .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic [2:0]   typ;
    logic [W-1:0] id, hops, clu, eng, q, kch;
  } pkt_t;

  int errors = 0;
  int checks = 0;

  task automatic chkI(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chkP(input string name, input pkt_t act, input pkt_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a queue of packets plus a single engine slot
  pkt_t q[$];
  pkt_t mUpd;
  bit   mBusy, mEn, mTmo;
  int   mSince, mDrops;

  function automatic pkt_t curPkt();
    return {pkt_type, pkt_source_id, pkt_source_hops, pkt_cluster_id, pkt_energy, pkt_qvalue, pkt_known_ch};
  endfunction

  function automatic pkt_t dutUpd();
    return {upd_type, upd_source_id, upd_source_hops, upd_cluster_id, upd_energy, upd_qvalue, upd_known_ch};
  endfunction

  task automatic modelEdge();
    bit ready;
    if (nrst) begin
      q.delete();
      mUpd = '0; mBusy = 0; mEn = 0; mTmo = 0; mSince = 0; mDrops = 0;
      return;
    end
    ready = q.size() < DEPTH;
    mEn = 0;
    if (mBusy) begin
      // mSince: 0 = issue cycle, k>=1 = k-th cycle waiting for done
      if (mSince >= 1 && upd_done) mBusy = 0;
`ifdef QUPD_TIMEOUT_EN
      else if (mSince == TMO) begin mBusy = 0; mTmo = 1; end
`endif
      else mSince++;
    end else if (q.size() > 0) begin
      mUpd = q.pop_front();
      mBusy = 1; mSince = 0; mEn = 1;
    end
    if (pkt_valid && ready) begin
      if (pkt_type == 3'b000) begin
        if (mDrops < 255) mDrops++;
      end else q.push_back(curPkt());
    end
  endtask

  task automatic checkModel();
    chkI("m_en", int'(upd_en), int'(mEn));
    chkI("m_busy", int'(busy), int'(mBusy));
    chkI("m_count", int'(fifo_count), q.size());
    chkI("m_ready", int'(pkt_ready), int'(q.size() < DEPTH));
    chkI("m_drops", int'(drop_count), mDrops);
    chkI("m_tmo", int'(timeout_err), int'(mTmo));
    chkP("m_upd", dutUpd(), mUpd);
  endtask

  task automatic cycle();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkModel();
  endtask

  task automatic setPkt(input logic [2:0] typ, input int id);
    pkt_type = typ;
    pkt_source_id = W'(id);
    pkt_source_hops = 16'd2;
    pkt_cluster_id = 16'd2;
    pkt_energy = 16'h8000;
    pkt_qvalue = 16'h3000;
    pkt_known_ch = 16'h0000;
  endtask

  task automatic doReset();
    nrst = 1; pkt_valid = 0; upd_done = 0;
    cycle(); cycle();
    nrst = 0;
  endtask

  typedef struct {
    bit rst, valid; logic [2:0] typ; int id; bit done;
    bit en, busy; int cnt; bit rdy; int drops;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int n;
    nrst = 1; pkt_valid = 0; upd_done = 0;
    setPkt(3'd0, 0);

    //              rst val typ   id  done  en busy cnt rdy drops
    vecs.push_back('{1, 0, 3'd0, 0, 0,   0, 0, 0, 1, 0});
    vecs.push_back('{1, 0, 3'd0, 0, 0,   0, 0, 0, 1, 0});
    vecs.push_back('{0, 1, 3'd5, 1, 0,   0, 0, 1, 1, 0});
    vecs.push_back('{0, 0, 3'd0, 0, 0,   1, 1, 0, 1, 0});
    vecs.push_back('{0, 0, 3'd0, 0, 0,   0, 1, 0, 1, 0});
    vecs.push_back('{0, 0, 3'd0, 0, 0,   0, 1, 0, 1, 0});
    vecs.push_back('{0, 0, 3'd0, 0, 0,   0, 1, 0, 1, 0});
    vecs.push_back('{0, 0, 3'd0, 0, 0,   0, 1, 0, 1, 0});
    vecs.push_back('{0, 0, 3'd0, 0, 1,   0, 0, 0, 1, 0});
    vecs.push_back('{0, 1, 3'd0, 0, 0,   0, 0, 0, 1, 1});
    vecs.push_back('{0, 1, 3'd0, 0, 0,   0, 0, 0, 1, 2});
    vecs.push_back('{0, 1, 3'd0, 0, 0,   0, 0, 0, 1, 3});
    vecs.push_back('{0, 0, 3'd0, 0, 0,   0, 0, 0, 1, 3});
    // done held high in IDLE and FIRE must not release the engine slot
    vecs.push_back('{0, 1, 3'd3, 7, 1,   0, 0, 1, 1, 3});
    vecs.push_back('{0, 0, 3'd0, 0, 1,   1, 1, 0, 1, 3});
    vecs.push_back('{0, 0, 3'd0, 0, 1,   0, 1, 0, 1, 3});
    vecs.push_back('{0, 0, 3'd0, 0, 0,   0, 1, 0, 1, 3});
    vecs.push_back('{0, 0, 3'd0, 0, 1,   0, 0, 0, 1, 3});
    vecs.push_back('{0, 0, 3'd0, 0, 0,   0, 0, 0, 1, 3});

    for (int i = 0; i < vecs.size(); i++) begin
      nrst = vecs[i].rst; pkt_valid = vecs[i].valid; upd_done = vecs[i].done;
      setPkt(vecs[i].typ, vecs[i].id);
      cycle();
      chkI($sformatf("vec%0d_en", i), int'(upd_en), int'(vecs[i].en));
      chkI($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].busy));
      chkI($sformatf("vec%0d_count", i), int'(fifo_count), vecs[i].cnt);
      chkI($sformatf("vec%0d_ready", i), int'(pkt_ready), int'(vecs[i].rdy));
      chkI($sformatf("vec%0d_drops", i), int'(drop_count), vecs[i].drops);
      if (i == 3) begin
        chkI("single_id", int'(upd_source_id), 1);
        chkI("single_energy", int'(upd_energy), 'h8000);
        chkI("single_q", int'(upd_qvalue), 'h3000);
        chkI("single_type", int'(upd_type), 5);
      end
    end
    upd_done = 0;

    // Backpressure: 5 pushes, one issued and four queued
    doReset();
    for (int k = 0; k < 5; k++) begin
      pkt_valid = 1;
      setPkt(3'(1 + k), 10 + k);
      cycle();
    end
    pkt_valid = 0;
    chkI("bp_ready_low", int'(pkt_ready), 0);
    chkI("bp_count_full", int'(fifo_count), 4);
    chkI("bp_first_id", int'(upd_source_id), 10);
    for (int k = 1; k < 5; k++) begin
      upd_done = 1;
      cycle();
      upd_done = 0;
      n = 0;
      while (!upd_en && n < 5) begin cycle(); n++; end
      chkI($sformatf("bp_latency%0d", k), n, 1);
      chkI($sformatf("bp_id%0d", k), int'(upd_source_id), 10 + k);
      chkI($sformatf("bp_ready%0d", k), int'(pkt_ready), 1);
      cycle();
    end
    upd_done = 1;
    cycle();
    upd_done = 0;
    chkI("bp_busy_end", int'(busy), 0);
    chkI("bp_count_end", int'(fifo_count), 0);

`ifdef QUPD_TIMEOUT_EN
    // Watchdog: engine never answers
    doReset();
    pkt_valid = 1; setPkt(3'd2, 40); cycle();
    setPkt(3'd2, 41); cycle();
    pkt_valid = 0;
    n = 0;
    while (!upd_en && n < 5) begin cycle(); n++; end
    chkI("wd_first_id", int'(upd_source_id), 40);
    n = 0;
    while (!timeout_err && n < 200) begin cycle(); n++; end
    chkI("wd_cycles", n, TMO + 1);
    n = 0;
    while (!upd_en && n < 5) begin cycle(); n++; end
    chkI("wd_next_issue", int'(upd_en), 1);
    chkI("wd_next_id", int'(upd_source_id), 41);
    pkt_valid = 1; setPkt(3'd4, 42); cycle();
    pkt_valid = 0; cycle();
    nrst = 1; cycle(); nrst = 0;
    chkI("wd_rst_count", int'(fifo_count), 0);
    chkI("wd_rst_tmo", int'(timeout_err), 0);
    chkI("wd_rst_busy", int'(busy), 0);
`else
    // Without the watchdog, WAIT holds indefinitely
    doReset();
    pkt_valid = 1; setPkt(3'd2, 40); cycle();
    pkt_valid = 0;
    for (int k = 0; k < 100; k++) cycle();
    chkI("nowd_busy", int'(busy), 1);
    chkI("nowd_tmo", int'(timeout_err), 0);
`endif

    // Random traffic against the model
    doReset();
    for (int k = 0; k < 3000; k++) begin
      nrst = ($urandom_range(0, 199) == 0);
      pkt_valid = ($urandom_range(0, 2) != 0);
      pkt_type = 3'($urandom_range(0, 7));
      pkt_source_id = W'($urandom); pkt_source_hops = W'($urandom);
      pkt_cluster_id = W'($urandom); pkt_energy = W'($urandom);
      pkt_qvalue = W'($urandom); pkt_known_ch = W'($urandom);
      upd_done = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qtable_update_sched.md
# qtable_update_sched

Packet scheduler for the Q-table update engine in the EER-RL node datapath. Received routing/data packets are buffered in a small FIFO and handed one at a time to the update engine: operand registers are loaded, a one-cycle `en` pulse is issued, and the scheduler waits for the engine's `done` before issuing the next packet. It sits between the packet receiver and the Q-table update engine. It is the only source of that engine's `en` and `f*` operand inputs.

## Interface
- `WORD_WIDTH`, 16: width of all packet fields (Q-values and energy are fixed-point words)
- `FIFO_DEPTH`, 4: packet FIFO entries; must be a power of two, at least 2
- `TIMEOUT_CYC`, 64: WAIT-state cycle limit; used only when the timeout watchdog is compiled in
- `clk`  in  1  single system clock; all logic is on the rising edge
- `nrst`  in  1  synchronous, active-high reset (port name kept for codebase consistency)
- `pkt_valid`  in  1  receiver offers a packet
- `pkt_ready`  out  1  FIFO can accept a packet; equals `fifo_count < FIFO_DEPTH`
- `pkt_source_id`, `pkt_source_hops`, `pkt_cluster_id`, `pkt_energy`, `pkt_qvalue`, `pkt_known_ch`  in  WORD_WIDTH each  packet fields
- `pkt_type`  in  3  packet type; 3'b000 is invalid
- `upd_en`  out  1  one-cycle start pulse to the update engine
- `upd_source_id`, `upd_source_hops`, `upd_cluster_id`, `upd_energy`, `upd_qvalue`, `upd_known_ch`  out  WORD_WIDTH each  registered operands to the engine
- `upd_type`  out  3  registered packet type to the engine
- `upd_done`  in  1  engine completion
- `busy`  out  1  high in every state other than IDLE
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current number of FIFO entries
- `drop_count`  out  8  saturating count of discarded invalid-type packets
- `timeout_err`  out  1  sticky watchdog flag

## Operation
- Push occurs when `pkt_valid & pkt_ready`. If `pkt_type==3'b000`, the packet is consumed but not written to the FIFO, and `drop_count` increments. `drop_count` saturates at 255.
- Simultaneous push and pop leaves `fifo_count` unchanged. Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head entry into the `upd_*` registers and go to FIRE. Otherwise stay in IDLE.
  - FIRE: `upd_en`=1 for exactly this cycle, then go to WAIT.
  - WAIT: `upd_done`=1 returns the FSM to IDLE. With the watchdog enabled, reaching TIMEOUT_CYC cycles in WAIT also returns to IDLE and sets `timeout_err`.
- `upd_done` is ignored in IDLE and FIRE. A stale done from the engine never releases the next packet.
- `upd_*` operands hold their value from the pop until the next pop.
- Reset values:
  - FSM in IDLE; FIFO emptied; `fifo_count`=0.
  - `upd_en`=0, `busy`=0, `drop_count`=0, `timeout_err`=0.
  - All `upd_*` outputs = 0; `pkt_ready`=1.
- A reset asserted mid-operation (in FIRE or WAIT) abandons the in-flight packet and all queued packets. It has priority over push, pop and done in the same cycle.

## Timing
- A push accepted on edge N into an empty FIFO with the FSM in IDLE produces:
  - `upd_*` valid and `fifo_count`=0 after edge N+1
  - `upd_en` high during the cycle after edge N+1, i.e. latency 2 edges
- `upd_done` sampled high on edge M in WAIT puts the FSM in IDLE after edge M. The next pop happens on edge M+1, and the next `upd_en` follows one cycle later.
- Minimum issue interval: 3 cycles (IDLE, FIRE, WAIT of 1 cycle).
- `pkt_ready` depends combinationally on `fifo_count` only; it never depends on `pkt_valid`.

## Configuration
- `QUPD_TIMEOUT_EN` defined:
  - An up-counter runs in WAIT and clears on leaving WAIT.
  - When it reaches TIMEOUT_CYC, `timeout_err` is set and the FSM returns to IDLE, dropping the packet.
  - `timeout_err` is cleared only by reset.
- `QUPD_TIMEOUT_EN` undefined:
  - No counter is present; WAIT waits indefinitely for `upd_done`.
  - `timeout_err` is tied to 0.

## Test plan
- Reset: assert `nrst` for 2 cycles → `upd_en`=0, `busy`=0, `fifo_count`=0, `pkt_ready`=1, `drop_count`=0.
- Single packet: push id=1, hops=2, cluster=2, energy=16'h8000, q=16'h3000, type=3'b101 → `upd_en` pulses 2 edges later with those operands. Done 5 cycles later → `busy`=0.
- Backpressure: push 5 packets with no done and FIFO_DEPTH=4 → one packet popped and 4 queued, then `pkt_ready`=0. Each done releases the next packet in FIFO order, and `pkt_ready` returns to 1.
- Invalid type: push type=3'b000 three times → `drop_count`=3, `fifo_count`=0, no `upd_en`.
- Stale done: hold `upd_done`=1 in IDLE and during FIRE → FSM stays in WAIT until done is sampled in WAIT.
- Watchdog (`QUPD_TIMEOUT_EN`, TIMEOUT_CYC=64): never assert done → `timeout_err`=1 after 64 WAIT cycles and the next queued packet issues. Reset in WAIT → FIFO empty and `timeout_err`=0.
